// File: rtl/rec_play_pkg.sv
`default_nettype none
// ============================================================================
// rec_play_pkg: state encoding and default widths for the record/play control
// Revision 1.0
// ============================================================================
package rec_play_pkg;

  localparam int c_addr_w_def = 18;
  localparam int c_data_w_def = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REC_WAIT  = 3'd1,
    S_REC_ACC   = 3'd2,
    S_PLAY_WAIT = 3'd3,
    S_PLAY_ACC  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rec_play_ctrl.sv
`default_nettype none
// ============================================================================
// rec_play_ctrl: sequences audio samples into SRAM on record and back out to the DAC on play
// Revision 1.0
// ============================================================================
module rec_play_ctrl
  import rec_play_pkg::*;
#(
  parameter int ADDR_W  = c_addr_w_def,
  parameter int DATA_W  = c_data_w_def,
  parameter int ACC_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_rec,
  input  logic              key_play,
  input  logic              key_stop,
  input  logic              smp_tick,
  input  logic [DATA_W-1:0] adc_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_read,
  output logic              sram_write,
  output logic              sram_record,
  output logic              sram_play,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [ADDR_W:0]   rec_len,
  output logic              busy,
  output logic              overrun
);

  localparam logic [2:0] c_cnt_last = 3'(ACC_CYC - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] smp_q, smp_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_valid_q, dac_valid_d;
  logic              overrun_q, overrun_d;
  logic              stop_pend_q, stop_pend_d;
  logic              sram_read_q, sram_read_d;
  logic              sram_write_q, sram_write_d;
  logic              sram_record_q, sram_record_d;
  logic              sram_play_q, sram_play_d;
  logic              busy_q, busy_d;

  logic              acc_last;
  logic              addr_max;
  logic [ADDR_W:0]   addr_inc;
  logic [ADDR_W-1:0] addr_next;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rec_len_d   = rec_len_q;
    cnt_d       = cnt_q;
    smp_d       = smp_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = 1'b0;
    overrun_d   = overrun_q;
    stop_pend_d = stop_pend_q;

    acc_last  = (cnt_q == c_cnt_last);
    addr_max  = (addr_q == {ADDR_W{1'b1}});
    addr_inc  = {1'b0, addr_q} + 1'b1;
    // The address saturates at the top word instead of wrapping to 0.
    addr_next = addr_max ? addr_q : addr_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        cnt_d       = 3'd0;
        if (key_stop) begin
          state_d = S_IDLE;
        end else if (key_rec) begin
          state_d   = S_REC_WAIT;
          addr_d    = '0;
          rec_len_d = '0;
          overrun_d = 1'b0;
        end else if (key_play && (rec_len_q != '0)) begin
          state_d   = S_PLAY_WAIT;
          addr_d    = '0;
          overrun_d = 1'b0;
        end
      end

      S_REC_WAIT: begin
        if (key_stop) begin
          state_d = S_IDLE;
        end else if (smp_tick) begin
          smp_d   = adc_data;
          cnt_d   = 3'd0;
          state_d = S_REC_ACC;
        end
      end

      S_REC_ACC: begin
        if (smp_tick) overrun_d = 1'b1;
        if (key_stop) stop_pend_d = 1'b1;
        if (acc_last) begin
          cnt_d     = 3'd0;
          rec_len_d = addr_inc;
          addr_d    = addr_next;
          state_d   = (addr_max || key_stop || stop_pend_q) ? S_IDLE : S_REC_WAIT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_PLAY_WAIT: begin
        if (key_stop) begin
          state_d = S_IDLE;
        end else if (smp_tick) begin
          cnt_d   = 3'd0;
          state_d = S_PLAY_ACC;
        end
      end

      S_PLAY_ACC: begin
        if (smp_tick) overrun_d = 1'b1;
        if (key_stop) stop_pend_d = 1'b1;
        if (acc_last) begin
          cnt_d       = 3'd0;
          dac_data_d  = sram_data;
          dac_valid_d = 1'b1;
          addr_d      = addr_next;
          state_d     = ((addr_inc == rec_len_q) || key_stop || stop_pend_q) ? S_IDLE : S_PLAY_WAIT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so the registered copies track the FSM exactly.
    sram_write_d  = (state_d == S_REC_ACC);
    sram_read_d   = (state_d == S_PLAY_ACC);
    sram_record_d = (state_d == S_REC_WAIT) || (state_d == S_REC_ACC);
    sram_play_d   = (state_d == S_PLAY_WAIT) || (state_d == S_PLAY_ACC);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      rec_len_q     <= '0;
      cnt_q         <= 3'd0;
      smp_q         <= '0;
      dac_data_q    <= '0;
      dac_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      stop_pend_q   <= 1'b0;
      sram_read_q   <= 1'b0;
      sram_write_q  <= 1'b0;
      sram_record_q <= 1'b0;
      sram_play_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rec_len_q     <= rec_len_d;
      cnt_q         <= cnt_d;
      smp_q         <= smp_d;
      dac_data_q    <= dac_data_d;
      dac_valid_q   <= dac_valid_d;
      overrun_q     <= overrun_d;
      stop_pend_q   <= stop_pend_d;
      sram_read_q   <= sram_read_d;
      sram_write_q  <= sram_write_d;
      sram_record_q <= sram_record_d;
      sram_play_q   <= sram_play_d;
      busy_q        <= busy_d;
    end
  end

  assign sram_data   = sram_record_q ? smp_q : {DATA_W{1'bz}};
  assign sram_addr   = addr_q;
  assign sram_read   = sram_read_q;
  assign sram_write  = sram_write_q;
  assign sram_record = sram_record_q;
  assign sram_play   = sram_play_q;
  assign dac_data    = dac_data_q;
  assign dac_valid   = dac_valid_q;
  assign rec_len     = rec_len_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_rec_play_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rec_play_ctrl: randomized record/playback sessions against a timing-rule model
// Revision 1.0
// ============================================================================
module tb_rec_play_ctrl;

  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int ACC = 2;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          key_rec  = 1'b0;
  logic          key_play = 1'b0;
  logic          key_stop = 1'b0;
  logic          smp_tick = 1'b0;
  logic [DW-1:0] adc_data = '0;
  wire  [DW-1:0] sram_data;
  logic [AW-1:0] sram_addr;
  logic          sram_read, sram_write, sram_record, sram_play;
  logic [DW-1:0] dac_data;
  logic          dac_valid, busy, overrun;
  logic [AW:0]   rec_len;

  logic [DW-1:0] mem [16];
  int vectors = 0;
  int errors  = 0;

  // Observed bus activity
  int            wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            wr_len[$];
  int            rd_addr[$];
  int            rd_len[$];
  logic [DW-1:0] dac_q[$];
  int            err_both, err_hold, err_dac;
  logic          wr_prev = 1'b0, rd_prev = 1'b0;

  // Model results
  logic [DW-1:0] m_vals[$];
  logic [DW-1:0] rec_vals[$];
  logic          m_ovr;

  rec_play_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(ACC)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .key_rec(key_rec), .key_play(key_play), .key_stop(key_stop),
    .smp_tick(smp_tick), .adc_data(adc_data),
    .sram_addr(sram_addr), .sram_read(sram_read), .sram_write(sram_write),
    .sram_record(sram_record), .sram_play(sram_play), .sram_data(sram_data),
    .dac_data(dac_data), .dac_valid(dac_valid), .rec_len(rec_len),
    .busy(busy), .overrun(overrun)
  );

  // SRAM model answers reads combinationally
  assign sram_data = sram_read ? mem[sram_addr] : {DW{1'bz}};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (sram_read && sram_write) err_both++;
      if (sram_write) begin
        if (!wr_prev) begin
          wr_addr.push_back(int'(sram_addr));
          wr_data.push_back(sram_data);
          wr_len.push_back(1);
          mem[sram_addr] = sram_data;
        end else begin
          if (int'(sram_addr) != wr_addr[$] || sram_data !== wr_data[$]) err_hold++;
          wr_len[wr_len.size()-1]++;
        end
      end
      if (sram_read) begin
        if (!rd_prev) begin
          rd_addr.push_back(int'(sram_addr));
          rd_len.push_back(1);
        end else begin
          if (int'(sram_addr) != rd_addr[$]) err_hold++;
          rd_len[rd_len.size()-1]++;
        end
      end
      if (dac_valid) begin
        dac_q.push_back(dac_data);
        if (!(rd_prev && !sram_read)) err_dac++;
      end
    end
    wr_prev = reset_n && sram_write;
    rd_prev = reset_n && sram_read;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_keys(input logic r, input logic p, input logic s);
    key_rec = r; key_play = p; key_stop = s;
    step();
    key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0;
  endtask

  task automatic tick(input logic [DW-1:0] v);
    adc_data = v; smp_tick = 1'b1;
    step();
    smp_tick = 1'b0;
  endtask

  task automatic clr_mon();
    wr_addr.delete(); wr_data.delete(); wr_len.delete();
    rd_addr.delete(); rd_len.delete(); dac_q.delete();
    err_both = 0; err_hold = 0; err_dac = 0;
  endtask

  // A tick at cycle t is served if it falls after the previous served tick's
  // access window (t_prev+1 .. t_prev+ACC); inside that window it is an overrun.
  task automatic run_session(input bit is_rec, input int n, input int mingap, input int maxgap,
                             input int cap, input bit do_stop);
    int t, last, cnt, gap;
    logic [DW-1:0] v;
    clr_mon();
    m_vals.delete();
    m_ovr = 1'b0;
    t = 0; last = -100; cnt = 0;
    pulse_keys(is_rec, !is_rec, 1'b0);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(maxgap, mingap);
      idle(gap - 1);
      t += gap;
      v = DW'($urandom);
      tick(v);
      if (t <= last + ACC) m_ovr = 1'b1;
      else if (cnt < cap) begin
        last = t; cnt++; m_vals.push_back(v);
      end
    end
    if (do_stop) begin
      idle($urandom_range(2, 0));
      pulse_keys(1'b0, 1'b0, 1'b1);
    end
    idle(ACC + 3);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle(3);
    vectors++;
    if ({sram_addr, rec_len, dac_data} !== '0) begin
      errors++; $display("FAIL reset_words: got addr=%0h len=%0h dac=%0h, want 0", sram_addr, rec_len, dac_data);
    end
    vectors++;
    if ({sram_read, sram_write, sram_record, sram_play, dac_valid, busy, overrun} !== 7'b0) begin
      errors++; $display("FAIL reset_bits: got %b, want 0000000",
                         {sram_read, sram_write, sram_record, sram_play, dac_valid, busy, overrun});
    end
    @(negedge clk) reset_n = 1'b1;
    step();
  endtask

  task automatic test_directed_record();
    logic [DW-1:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    clr_mon();
    pulse_keys(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(9);
      tick(vals[i]);
    end
    idle(9);
    pulse_keys(1'b0, 1'b0, 1'b1);
    idle(3);
    vectors++;
    if (wr_addr.size() != 3) begin
      errors++; $display("FAIL dir_wr_count: got %0d, want 3", wr_addr.size());
    end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      vectors++;
      if (wr_addr[i] != i || wr_data[i] !== vals[i] || wr_len[i] != ACC) begin
        errors++; $display("FAIL dir_wr%0d: got addr=%0d data=%h len=%0d, want addr=%0d data=%h len=%0d",
                           i, wr_addr[i], wr_data[i], wr_len[i], i, vals[i], ACC);
      end
    end
    vectors++;
    if (rec_len !== 5'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL dir_rec_end: got rec_len=%0d busy=%b, want 3 0", rec_len, busy);
    end
    rec_vals.delete();
    for (int i = 0; i < 3; i++) rec_vals.push_back(vals[i]);
  endtask

  task automatic test_directed_play();
    clr_mon();
    pulse_keys(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(9);
      tick(DW'($urandom));
    end
    idle(5);
    vectors++;
    if (busy !== 1'b0 || sram_play !== 1'b0) begin
      errors++; $display("FAIL dir_play_idle: got busy=%b play=%b, want 0 0", busy, sram_play);
    end
    tick(16'h0bad);
    idle(5);
    vectors++;
    if (rd_addr.size() != 3 || dac_q.size() != 3) begin
      errors++; $display("FAIL dir_rd_count: got reads=%0d dac=%0d, want 3 3", rd_addr.size(), dac_q.size());
    end
    for (int i = 0; i < 3 && i < rd_addr.size() && i < dac_q.size(); i++) begin
      vectors++;
      if (rd_addr[i] != i || rd_len[i] != ACC || dac_q[i] !== rec_vals[i]) begin
        errors++; $display("FAIL dir_rd%0d: got addr=%0d len=%0d dac=%h, want addr=%0d len=%0d dac=%h",
                           i, rd_addr[i], rd_len[i], dac_q[i], i, ACC, rec_vals[i]);
      end
    end
    vectors++;
    if (dac_data !== 16'h3333 || err_dac != 0 || err_both != 0) begin
      errors++; $display("FAIL dir_dac: got dac=%h dac_err=%0d both_err=%0d, want 3333 0 0", dac_data, err_dac, err_both);
    end
  endtask

  task automatic test_keys_idle();
    pulse_keys(1'b1, 1'b1, 1'b1);
    idle(1);
    vectors++;
    if (busy !== 1'b0 || rec_len !== 5'd3) begin
      errors++; $display("FAIL keys_all: got busy=%b rec_len=%0d, want 0 3", busy, rec_len);
    end
    pulse_keys(1'b1, 1'b0, 1'b0);
    pulse_keys(1'b0, 1'b0, 1'b1);
    idle(1);
    vectors++;
    if (busy !== 1'b0 || rec_len !== 5'd0) begin
      errors++; $display("FAIL keys_rec_stop: got busy=%b rec_len=%0d, want 0 0", busy, rec_len);
    end
    pulse_keys(1'b0, 1'b1, 1'b0);
    idle(1);
    vectors++;
    if (busy !== 1'b0 || sram_play !== 1'b0) begin
      errors++; $display("FAIL keys_play_empty: got busy=%b play=%b, want 0 0", busy, sram_play);
    end
  endtask

  task automatic test_overrun();
    clr_mon();
    pulse_keys(1'b1, 1'b0, 1'b0);
    idle(2);
    tick(16'haaaa);
    tick(16'hbbbb);
    idle(5);
    vectors++;
    if (overrun !== 1'b1 || wr_addr.size() != 1 || busy !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got ovr=%b writes=%0d busy=%b, want 1 1 1", overrun, wr_addr.size(), busy);
    end
    pulse_keys(1'b0, 1'b0, 1'b1);
    idle(2);
    vectors++;
    if (overrun !== 1'b1 || rec_len !== 5'd1) begin
      errors++; $display("FAIL ovr_sticky: got ovr=%b rec_len=%0d, want 1 1", overrun, rec_len);
    end
    pulse_keys(1'b1, 1'b0, 1'b0);
    vectors++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ovr_clear: got ovr=%b busy=%b, want 0 1", overrun, busy);
    end
    pulse_keys(1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic test_random(input int iters);
    for (int k = 0; k < iters; k++) begin
      run_session(1'b1, $urandom_range(24, 4), 1, 6, 16, 1'b1);
      rec_vals = m_vals;
      vectors++;
      if (wr_addr.size() != m_vals.size()) begin
        errors++; $display("FAIL rnd_wr_count[%0d]: got %0d, want %0d", k, wr_addr.size(), m_vals.size());
      end
      for (int i = 0; i < wr_addr.size() && i < m_vals.size(); i++) begin
        vectors++;
        if (wr_addr[i] != i || wr_data[i] !== m_vals[i] || wr_len[i] != ACC) begin
          errors++; $display("FAIL rnd_wr[%0d.%0d]: got addr=%0d data=%h len=%0d, want addr=%0d data=%h len=%0d",
                             k, i, wr_addr[i], wr_data[i], wr_len[i], i, m_vals[i], ACC);
        end
      end
      vectors++;
      if (rec_len !== (AW+1)'(m_vals.size()) || overrun !== m_ovr || busy !== 1'b0 ||
          err_both != 0 || err_hold != 0) begin
        errors++; $display("FAIL rnd_rec_end[%0d]: got len=%0d ovr=%b busy=%b both=%0d hold=%0d, want len=%0d ovr=%b busy=0 0 0",
                           k, rec_len, overrun, busy, err_both, err_hold, m_vals.size(), m_ovr);
      end

      run_session(1'b0, $urandom_range(rec_vals.size() + 3, 1), 1, 6, rec_vals.size(), 1'b1);
      vectors++;
      if (rd_addr.size() != m_vals.size() || dac_q.size() != m_vals.size()) begin
        errors++; $display("FAIL rnd_rd_count[%0d]: got reads=%0d dac=%0d, want %0d",
                           k, rd_addr.size(), dac_q.size(), m_vals.size());
      end
      for (int i = 0; i < rd_addr.size() && i < dac_q.size() && i < m_vals.size(); i++) begin
        vectors++;
        if (rd_addr[i] != i || rd_len[i] != ACC || dac_q[i] !== rec_vals[i]) begin
          errors++; $display("FAIL rnd_rd[%0d.%0d]: got addr=%0d len=%0d dac=%h, want addr=%0d len=%0d dac=%h",
                             k, i, rd_addr[i], rd_len[i], dac_q[i], i, ACC, rec_vals[i]);
        end
      end
      vectors++;
      if (overrun !== m_ovr || busy !== 1'b0 || err_dac != 0 || err_both != 0 || err_hold != 0) begin
        errors++; $display("FAIL rnd_play_end[%0d]: got ovr=%b busy=%b dac_err=%0d both=%0d hold=%0d, want ovr=%b 0 0 0 0",
                           k, overrun, busy, err_dac, err_both, err_hold, m_ovr);
      end
    end
  endtask

  task automatic test_capacity();
    run_session(1'b1, 20, ACC + 1, ACC + 4, 16, 1'b0);
    rec_vals = m_vals;
    vectors++;
    if (wr_addr.size() != 16 || rec_len !== 5'd16 || busy !== 1'b0) begin
      errors++; $display("FAIL cap_rec: got writes=%0d rec_len=%0d busy=%b, want 16 16 0", wr_addr.size(), rec_len, busy);
    end
    vectors++;
    if (wr_addr.size() == 16 && (wr_addr[15] != 15 || wr_data[15] !== m_vals[15])) begin
      errors++; $display("FAIL cap_last_wr: got addr=%0d data=%h, want 15 %h", wr_addr[15], wr_data[15], m_vals[15]);
    end
    run_session(1'b0, 20, ACC + 1, ACC + 4, 16, 1'b0);
    vectors++;
    if (rd_addr.size() != 16 || dac_q.size() != 16 || busy !== 1'b0) begin
      errors++; $display("FAIL cap_play: got reads=%0d dac=%0d busy=%b, want 16 16 0", rd_addr.size(), dac_q.size(), busy);
    end
    vectors++;
    if (dac_q.size() == 16 && dac_q[15] !== rec_vals[15]) begin
      errors++; $display("FAIL cap_last_dac: got %h, want %h", dac_q[15], rec_vals[15]);
    end
  endtask

  task automatic test_reset_mid_access();
    clr_mon();
    pulse_keys(1'b1, 1'b0, 1'b0);
    idle(1);
    tick(16'h1234);
    idle(4);
    tick(16'h5a5a);
    vectors++;
    if (sram_write !== 1'b1 || rec_len !== 5'd1) begin
      errors++; $display("FAIL mid_pre: got write=%b rec_len=%0d, want 1 1", sram_write, rec_len);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({sram_addr, rec_len, dac_data} !== '0) begin
      errors++; $display("FAIL mid_words: got addr=%0h len=%0h dac=%0h, want 0", sram_addr, rec_len, dac_data);
    end
    vectors++;
    if ({sram_read, sram_write, sram_record, sram_play, dac_valid, busy, overrun} !== 7'b0) begin
      errors++; $display("FAIL mid_bits: got %b, want 0000000",
                         {sram_read, sram_write, sram_record, sram_play, dac_valid, busy, overrun});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    idle(2);
    vectors++;
    if (busy !== 1'b0 || rec_len !== 5'd0 || sram_record !== 1'b0) begin
      errors++; $display("FAIL mid_after: got busy=%b rec_len=%0d record=%b, want 0 0 0", busy, rec_len, sram_record);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_directed_record();
    test_directed_play();
    test_keys_idle();
    test_overrun();
    test_random(4);
    test_capacity();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
